// File: rtl/seq_rotator.sv
// seq_rotator: multi-cycle ROL/ROR/SLL/SRA unit with a start/busy/done handshake.
// It applies one bit step per clock.
// Optional build macro SEQ_ROTATOR_FAST_EN applies two steps per clock while at least two remain.
module seq_rotator #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   data_in,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_ROR = 2'b01;
    localparam logic [1:0] OP_SLL = 2'b10;
    localparam logic [1:0] OP_SRA = 2'b11;

    state_t             state;
    logic [SHAMT_W-1:0] cnt;
    logic [1:0]         op_q;

    // Single-position step of the selected operation
    function automatic logic [WIDTH-1:0] step1(input logic [WIDTH-1:0] v, input logic [1:0] o);
        logic [WIDTH-1:0] r;
        r = v;
        case (o)
            OP_ROL: r = {v[WIDTH-2:0], v[WIDTH-1]};
            OP_ROR: r = {v[0], v[WIDTH-1:1]};
            OP_SLL: r = {v[WIDTH-2:0], 1'b0};
            OP_SRA: r = {v[WIDTH-1], v[WIDTH-1:1]};
            default: r = v;
        endcase
        return r;
    endfunction

    // Control FSM plus working register; busy/done are registered alongside the state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            result <= '0;
            cnt    <= '0;
            op_q   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        result <= data_in;
                        cnt    <= shamt;
                        op_q   <= op;
                        state  <= RUN;
                        busy   <= 1'b1;
                        done   <= 1'b0;
                    end
                end
                RUN: begin
                    if (cnt == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
`ifdef SEQ_ROTATOR_FAST_EN
                    end else if ({1'b0, cnt} >= (SHAMT_W+1)'(2)) begin
                        result <= step1(step1(result, op_q), op_q);
                        cnt    <= cnt - SHAMT_W'(2);
`endif
                    end else begin
                        result <= step1(result, op_q);
                        cnt    <= cnt - SHAMT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_rotator.sv
// Directed self-checking bench for seq_rotator (WIDTH=32, SHAMT_W=5).
module tb_seq_rotator;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [4:0]  shamt;
    logic [31:0] data_in;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;

    seq_rotator #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .shamt   (shamt),
        .data_in (data_in),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    always #5 clk = ~clk;

    // Count one comparison and report a mismatch
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Cycles from the accepting edge until done is seen
    function automatic int exp_lat(input int sh);
`ifdef SEQ_ROTATOR_FAST_EN
        return (sh + 1) / 2 + 1;
`else
        return sh + 1;
`endif
    endfunction

    // Wait for done with a cycle budget; returns cycles waited and busy-high samples
    task automatic wait_done(output int cyc, output int bcnt);
        cyc  = 0;
        bcnt = 0;
        while (!done && cyc < 200) begin
            if (busy) bcnt++;
            @(negedge clk);
            cyc++;
        end
    endtask

    // Issue one operation, scramble inputs after acceptance, check result, latency and busy width
    task automatic run_op(input string tag, input logic [1:0] o, input logic [4:0] sh,
                          input logic [31:0] d, input logic [31:0] exp);
        int cyc, bcnt;
        @(negedge clk);
        start = 1'b1; op = o; shamt = sh; data_in = d;
        @(negedge clk);
        start = 1'b0; op = ~o; shamt = ~sh; data_in = ~d;
        wait_done(cyc, bcnt);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_res"},  result, exp);
        chk({tag, "_lat"},  32'(cyc), 32'(exp_lat(int'(sh))));
        chk({tag, "_busy"}, 32'(bcnt), 32'(exp_lat(int'(sh))));
    endtask

    initial begin
        int cyc, bcnt;
        reset = 1'b1; start = 1'b0; op = 2'b00; shamt = '0; data_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_res",  result, 32'h0);
        reset = 1'b0;

        // Main function and boundaries
        run_op("rol4",   2'b00, 5'd4,  32'h8000_0001, 32'h0000_0018);
        // Result held in DONE
        repeat (3) @(negedge clk);
        chk("hold_done", 32'(done), 32'd1);
        chk("hold_res",  result, 32'h0000_0018);
        run_op("ror1",   2'b01, 5'd1,  32'h0000_0001, 32'h8000_0000);
        run_op("sll31",  2'b10, 5'd31, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("sra31n", 2'b11, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("sra31p", 2'b11, 5'd31, 32'h4000_0000, 32'h0000_0000);
        run_op("rol0",   2'b00, 5'd0,  32'h1234_5678, 32'h1234_5678);
        run_op("ror0",   2'b01, 5'd0,  32'h1234_5678, 32'h1234_5678);
        run_op("sll0",   2'b10, 5'd0,  32'h1234_5678, 32'h1234_5678);
        run_op("sra0",   2'b11, 5'd0,  32'h1234_5678, 32'h1234_5678);
        run_op("rol31",  2'b00, 5'd31, 32'h0000_0001, 32'h8000_0000);
        run_op("ror8",   2'b01, 5'd8,  32'h1234_5678, 32'h7812_3456);
        run_op("sll4",   2'b10, 5'd4,  32'h1234_5678, 32'h2345_6780);
        run_op("sra4",   2'b11, 5'd4,  32'hF000_0000, 32'hFF00_0000);
        run_op("rol5",   2'b00, 5'd5,  32'h8000_0001, 32'h0000_0030);

        // start pulsed during RUN is ignored
        @(negedge clk);
        start = 1'b1; op = 2'b00; shamt = 5'd8; data_in = 32'h0000_0001;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; op = 2'b10; shamt = 5'd1; data_in = 32'h0000_FFFF;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, bcnt);
        chk("ign_res", result, 32'h0000_0100);
        chk("ign_lat", 32'(cyc + 2), 32'(exp_lat(8)));

        // Reset mid-RUN aborts at once
        @(negedge clk);
        start = 1'b1; op = 2'b00; shamt = 5'd20; data_in = 32'h0000_00FF;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_res",  result, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("mrst_idle", 32'(busy), 32'd0);

        // start held high: done pulses for one cycle, new data sampled on re-accept
        start = 1'b1; op = 2'b00; shamt = 5'd2; data_in = 32'h0000_0001;
        @(negedge clk);
        data_in = 32'h0000_0002;
        wait_done(cyc, bcnt);
        chk("b2b_res1", result, 32'h0000_0004);
        chk("b2b_lat1", 32'(cyc), 32'(exp_lat(2)));
        @(negedge clk);
        chk("b2b_drop", 32'(done), 32'd0);
        chk("b2b_busy", 32'(busy), 32'd1);
        start = 1'b0;
        wait_done(cyc, bcnt);
        chk("b2b_res2", result, 32'h0000_0008);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
